// File: rtl/alu_pkg.sv
// Shared ALU definitions: 3-bit opcode type, opcode encodings used by the
// ALU and its issue stage, and the output-register state type.
package alu_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD = 3'b000;
    localparam opcode_t OP_SUB = 3'b001;
    localparam opcode_t OP_AND = 3'b010;
    localparam opcode_t OP_OR  = 3'b011;
    localparam opcode_t OP_XOR = 3'b100;
    localparam opcode_t OP_NOT = 3'b101;
    localparam opcode_t OP_SHL = 3'b110;
    localparam opcode_t OP_SHR = 3'b111;

    // Output register occupancy; the state bit doubles as out_valid.
    typedef enum logic {
        OutEmpty = 1'b0,
        OutFull  = 1'b1
    } out_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issue stage.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i at the tail (ignored when full)
//   wdata_i      command word
//   pop_i        drop the head entry (ignored when empty)
//   head_o       entry at the head (undefined when empty)
//   count_o      number of stored entries, 0..Depth
module alu_cmd_fifo #(
    parameter int unsigned Width = 11,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && (count_q != (AW+1)'(Depth));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed below count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU. Commands are buffered in a
// FIFO, the head is presented to the ALU, and the ALU result is captured in a
// registered output stage so consumer back-pressure never reaches the ALU.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready            command handshake
//   in_a, in_b, in_opcode        command payload
//   alu_a, alu_b, alu_opcode     drive to the external ALU (zero when idle)
//   alu_result                   ALU result, N+1 bits
//   out_valid/out_ready          result handshake
//   out_result, out_opcode       registered result and its opcode
//   op_count                     consumed results, wraps at 16 bits
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_opcode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    input  logic [N:0]   alu_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_result,
    output logic [2:0]   out_opcode,
    output logic [15:0]  op_count
);

    localparam int unsigned CmdW = 2 * N + 3;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [CmdW-1:0] wdata;
    logic [CmdW-1:0] head;
    logic [CntW-1:0] count;
    logic            fifo_empty;
    logic            push;
    logic            load;
    opcode_t         head_op;

    out_state_e      out_state_q, out_state_d;
    logic [N:0]      out_result_q, out_result_d;
    opcode_t         out_opcode_q, out_opcode_d;
    logic [15:0]     op_count_q, op_count_d;

    assign wdata      = {in_a, in_b, in_opcode};
    assign fifo_empty = (count == '0);
    // Ready is a function of occupancy only: a full FIFO never accepts, even
    // when the head is popped in the same cycle.
    assign in_ready   = (count != CntW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head_op    = head[2:0];
    assign load       = !fifo_empty && ((out_state_q == OutEmpty) || out_ready);

    alu_cmd_fifo #(
        .Width (CmdW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (load),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (!fifo_empty) begin
            alu_a      = head[CmdW-1 -: N];
            alu_b      = head[N+2 -: N];
            alu_opcode = head_op;
        end
    end

    always_comb begin
        out_state_d  = out_state_q;
        out_result_d = out_result_q;
        out_opcode_d = out_opcode_q;
        op_count_d   = op_count_q;
        if (load) begin
            out_state_d  = OutFull;
            out_result_d = alu_result;
            out_opcode_d = head_op;
        end else if (out_ready) begin
            out_state_d = OutEmpty;
        end
        if ((out_state_q == OutFull) && out_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q  <= OutEmpty;
            out_result_q <= '0;
            out_opcode_q <= '0;
            op_count_q   <= '0;
        end else begin
            out_state_q  <= out_state_d;
            out_result_q <= out_result_d;
            out_opcode_q <= out_opcode_d;
            op_count_q   <= op_count_d;
        end
    end

    assign out_valid  = (out_state_q == OutFull);
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU alongside.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [2:0]   in_opcode;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_opcode;
    logic [N:0]   alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_result;
    logic [2:0]   out_opcode;
    logic [15:0]  op_count;

    int checks;
    int failures;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } cmd_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [N:0]   res;
    } vec_t;

    // Reference model: queued commands plus the one-entry result slot.
    cmd_t        mq[$];
    logic        m_valid;
    logic [N:0]  m_result;
    logic [2:0]  m_op;
    logic [15:0] m_count;

    function automatic logic [N:0] alu_ref(logic [N-1:0] a, logic [N-1:0] b, logic [2:0] op);
        logic [N:0] ea;
        logic [N:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea & eb;
            3'd3:    return ea | eb;
            3'd4:    return ea ^ eb;
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {1'b0, a >> 1};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_opcode);

    alu_issue_stage #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid  = 1'b0;
        m_result = '0;
        m_op     = '0;
        m_count  = '0;
    endtask

    // Advance the model by one edge using the currently driven inputs,
    // then let the DUT take the same edge.
    task automatic tick();
        bit   acc;
        bit   consume;
        bit   ld;
        cmd_t c;
        acc     = in_valid && (mq.size() < DEPTH);
        consume = m_valid && out_ready;
        ld      = (mq.size() != 0) && (!m_valid || out_ready);
        if (consume) m_count = m_count + 16'd1;
        if (ld) begin
            c        = mq.pop_front();
            m_result = alu_ref(c.a, c.b, c.op);
            m_op     = c.op;
            m_valid  = 1'b1;
        end else if (consume) begin
            m_valid = 1'b0;
        end
        if (acc) begin
            c.a  = in_a;
            c.b  = in_b;
            c.op = in_opcode;
            mq.push_back(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [N-1:0] ea;
        logic [N-1:0] eb;
        logic [2:0]   eo;
        ea = '0;
        eb = '0;
        eo = '0;
        if (mq.size() != 0) begin
            ea = mq[0].a;
            eb = mq[0].b;
            eo = mq[0].op;
        end
        chk("m_in_ready", in_ready, (mq.size() < DEPTH));
        chk("m_out_valid", out_valid, m_valid);
        chk("m_out_result", out_result, m_result);
        chk("m_out_opcode", out_opcode, m_op);
        chk("m_op_count", op_count, m_count);
        chk("m_alu_a", alu_a, ea);
        chk("m_alu_b", alu_b, eb);
        chk("m_alu_op", alu_opcode, eo);
    endtask

    task automatic drive_random();
        in_a      = N'($urandom);
        in_b      = N'($urandom);
        in_opcode = 3'($urandom);
    endtask

    vec_t       vec [8];
    int         accepted;
    bit         have_held;
    logic [N:0] held_res;
    logic [2:0] held_op;

    initial begin
        checks   = 0;
        failures = 0;
        vec[0] = '{a: 4'd9,     b: 4'd8,     op: OP_ADD, res: 5'b10001};
        vec[1] = '{a: 4'd3,     b: 4'd5,     op: OP_SUB, res: 5'b11110};
        vec[2] = '{a: 4'b1010,  b: 4'b0110,  op: OP_AND, res: 5'b00010};
        vec[3] = '{a: 4'b1010,  b: 4'b0110,  op: OP_OR,  res: 5'b01110};
        vec[4] = '{a: 4'b1010,  b: 4'b0110,  op: OP_XOR, res: 5'b01100};
        vec[5] = '{a: 4'b1010,  b: 4'b0110,  op: OP_NOT, res: 5'b00101};
        vec[6] = '{a: 4'b1010,  b: 4'b0110,  op: OP_SHL, res: 5'b10100};
        vec[7] = '{a: 4'b1010,  b: 4'b0110,  op: OP_SHR, res: 5'b00101};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_opcode = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_opcode", out_opcode, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_opcode, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table stream: one result per cycle, no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid  = 1'b1;
                in_a      = vec[i].a;
                in_b      = vec[i].b;
                in_opcode = vec[i].op;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check_model();
            if (i >= 1) begin
                chk("vec_valid", out_valid, 1);
                chk("vec_result", out_result, vec[i-1].res);
                chk("vec_opcode", out_opcode, vec[i-1].op);
            end
        end
        tick();
        check_model();
        chk("vec_op_count", op_count, 8);
        chk("vec_drained", out_valid, 0);

        // Stall: 5 accepted (4 in FIFO + 1 held), first result held stable.
        out_ready = 1'b0;
        accepted  = 0;
        have_held = 1'b0;
        held_res  = '0;
        held_op   = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            drive_random();
            if (in_ready) accepted++;
            tick();
            check_model();
            if (out_valid && !have_held) begin
                have_held = 1'b1;
                held_res  = out_result;
                held_op   = out_opcode;
            end else if (have_held) begin
                chk("stall_hold_result", out_result, held_res);
                chk("stall_hold_opcode", out_opcode, held_op);
            end
        end
        chk("stall_accepted", accepted, 5);
        chk("stall_in_ready", in_ready, 0);

        // Full FIFO with a pop and in_valid high: no push, space opens next cycle.
        in_valid = 1'b1;
        drive_random();
        out_ready = 1'b1;
        tick();
        check_model();
        chk("fullpop_in_ready", in_ready, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        check_model();
        chk("fullpop_still_ready", in_ready, 1);

        // Drain in order at one per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, 1);
            tick();
            check_model();
        end
        chk("drain_empty", out_valid, 0);

        // Reset with 3 queued commands and a held result.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            drive_random();
            tick();
            check_model();
        end
        in_valid = 1'b0;
        chk("prerst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_alu_op", alu_opcode, 0);
        chk("arst_op_count", op_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model();
            chk("postrst_no_stale", out_valid, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive_random();
            tick();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
